can_tx_arbiter: RTL and testbench
=================================

Name: can_tx_arbiter

Overview:
- Shares one CAN transmit controller among NUM_REQ AXI4-Stream frame sources (engine-rev/speed generators, diagnostics, etc.).
- Grants the pending request with the lowest CAN ID, mirroring bus priority.
- Registers the frame, forwards it to the controller, then routes the controller's 3-bit result back to the granted requester only.
- Sits between the per-function data generators and the single CAN TX core.

Parameters:
- NUM_REQ, 2: number of requesters; must be >= 2.
- MAX_RETRY, 3: automatic resend limit after arbitration loss; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req_tdata  in  NUM_REQ*64  per-requester frame payload; requester i occupies slice [i*64 +: 64].
- req_tid  in  NUM_REQ*11  per-requester CAN ID; slice [i*11 +: 11].
- req_tkeep  in  NUM_REQ*8  per-requester byte enables.
- req_tvalid  in  NUM_REQ  per-requester frame valid.
- req_tready  out  NUM_REQ  per-requester accept, one-hot or zero.
- res_tdata  out  3  result broadcast to all requesters: {arb_lost, ack_err, bitmon_err}.
- res_tvalid  out  NUM_REQ  result valid, one-hot to the granted requester.
- res_tready  in  NUM_REQ  per-requester result accept.
- can_tdata  out  64  frame payload to the CAN TX core.
- can_tid  out  11  frame ID to the CAN TX core.
- can_tkeep  out  8  frame byte enables to the CAN TX core.
- can_tvalid  out  1  frame valid to the CAN TX core.
- can_tready  in  1  CAN TX core accepts frame.
- can_res_tdata  in  3  result from the CAN TX core.
- can_res_tvalid  in  1  result valid from the CAN TX core.
- can_res_tready  out  1  accept result from the CAN TX core.
- busy  out  1  high in any state other than IDLE.
- grant_idx  out  $clog2(NUM_REQ)  index of the current or last granted requester.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - All tvalid/tready outputs are 0; can_tdata/can_tid/can_tkeep/res_tdata are 0.
  - grant_idx=0; busy=0; retry count=0.
- IDLE:
  - Winner = valid requester with the numerically smallest tid; ties go to the lowest index.
  - req_tready[winner]=1 combinationally in the same cycle; all other ready bits are 0.
  - On that handshake, latch tdata/tid/tkeep and grant_idx, then go to SEND.
  - No valid requests: stay in IDLE, all readies 0.
- SEND:
  - can_tvalid=1 driven from registers; the frame is stable until can_tready.
  - First can_tvalid is one cycle after the req handshake.
  - On can_tvalid&can_tready, go to WAIT_RES.
- WAIT_RES:
  - can_res_tready=1.
  - On handshake, latch can_res_tdata into res_tdata, then go to RESULT.
  - can_res_tvalid arriving in other states is not accepted (ready=0).
- RESULT:
  - res_tvalid[grant_idx]=1 and res_tdata held.
  - On res_tready[grant_idx], go to IDLE; the new arbitration happens in that next IDLE cycle (minimum two-cycle gap between grants).
- Requests changing while not granted are ignored; no preemption once a frame is latched.
- req_tvalid dropping in the IDLE grant cycle is an AXI protocol violation; behaviour is undefined.
- A requester may re-request immediately after its result; it competes normally.
- rst asserted mid-SEND or mid-WAIT_RES aborts the transaction:
  - No result is returned.
  - The CAN TX core must be reset by the same rst.

Optional Feature:
- Macro: CAN_TX_ARBITER_RETRY_EN.
- Defined:
  - In WAIT_RES, if can_res_tdata[2]=1 (arbitration lost) and retry count < MAX_RETRY, increment the count and return to SEND with the same latched frame; no result goes to the requester.
  - Otherwise go to RESULT.
  - Retry count clears on each new grant.
  - A requester therefore sees arb_lost=1 only after MAX_RETRY+1 total attempts.
- Undefined: every result is forwarded unchanged; no retry counter is synthesised.

Decomposition:
- Package can_tx_arb_pkg holds:
  - State enum {IDLE, SEND, WAIT_RES, RESULT}.
  - Result bit index constants RES_ARB_LOST=2, RES_ACK_ERR=1, RES_BITMON_ERR=0.
  - Widths CAN_ID_W=11, CAN_DATA_W=64, CAN_KEEP_W=8.
  - Packed struct can_frame_t {tid, tdata, tkeep}.
- Sub-module can_id_min_select: combinational lowest-ID/lowest-index finder over NUM_REQ valid entries; outputs winner index and any_valid.

Test Plan:
- Simultaneous requests: req0 tid=0x3E9, req1 tid=0x3D9 in the same cycle → req1 granted first, can_tid=0x3D9; after req1's result, req0 is granted, can_tid=0x3E9.
- Tie: both requests tid=0x100 → req0 first (grant_idx=0), then req1.
- Backpressure: can_tready low for 10 cycles → can_tdata/can_tid stable throughout; res_tready[1] low for 5 cycles → res_tvalid[1] and res_tdata=3'b010 held, res_tvalid[0]=0.
- Result routing: grant req1, core returns 3'b011 → only res_tvalid[1] pulses, with res_tdata=3'b011.
- Retry (macro on, MAX_RETRY=3): core returns 3'b100 three times, then 3'b000 → four can_tvalid handshakes, one res_tvalid with 3'b000. Same scenario with five 3'b100 results → requester sees 3'b100 after the 4th attempt.
- Reset mid-WAIT_RES → next cycle busy=0, all valids 0, grant_idx=0; a fresh request is granted normally afterwards.

Source files
------------

// File: rtl/can_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : can_tx_arb_pkg
//  Brief    : Shared types and constants for the CAN TX arbiter slice.
//  Revision : 1.0 - initial release
// ============================================================================
package can_tx_arb_pkg;

    localparam int CAN_ID_W   = 11;
    localparam int CAN_DATA_W = 64;
    localparam int CAN_KEEP_W = 8;

    // Bit positions inside the 3-bit result word {arb_lost, ack_err, bitmon_err}
    localparam int RES_ARB_LOST   = 2;
    localparam int RES_ACK_ERR    = 1;
    localparam int RES_BITMON_ERR = 0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_RES = 2'd2,
        RESULT   = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic [CAN_ID_W-1:0]   tid;
        logic [CAN_DATA_W-1:0] tdata;
        logic [CAN_KEEP_W-1:0] tkeep;
    } can_frame_t;

endpackage
`default_nettype wire

// File: rtl/can_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : can_tx_arbiter_if
//  Brief    : Requester, result and CAN-core stream bundle for can_tx_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface can_tx_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import can_tx_arb_pkg::*;

    logic [NUM_REQ*CAN_DATA_W-1:0] req_tdata;
    logic [NUM_REQ*CAN_ID_W-1:0]   req_tid;
    logic [NUM_REQ*CAN_KEEP_W-1:0] req_tkeep;
    logic [NUM_REQ-1:0]            req_tvalid;
    logic [NUM_REQ-1:0]            req_tready;

    logic [2:0]                    res_tdata;
    logic [NUM_REQ-1:0]            res_tvalid;
    logic [NUM_REQ-1:0]            res_tready;

    logic [CAN_DATA_W-1:0]         can_tdata;
    logic [CAN_ID_W-1:0]           can_tid;
    logic [CAN_KEEP_W-1:0]         can_tkeep;
    logic                          can_tvalid;
    logic                          can_tready;

    logic [2:0]                    can_res_tdata;
    logic                          can_res_tvalid;
    logic                          can_res_tready;

    // Arbiter side
    modport slave (
        input  req_tdata, req_tid, req_tkeep, req_tvalid,
        output req_tready,
        output res_tdata, res_tvalid,
        input  res_tready,
        output can_tdata, can_tid, can_tkeep, can_tvalid,
        input  can_tready,
        input  can_res_tdata, can_res_tvalid,
        output can_res_tready
    );

    // Requesters plus CAN core side
    modport master (
        output req_tdata, req_tid, req_tkeep, req_tvalid,
        input  req_tready,
        input  res_tdata, res_tvalid,
        output res_tready,
        input  can_tdata, can_tid, can_tkeep, can_tvalid,
        output can_tready,
        output can_res_tdata, can_res_tvalid,
        input  can_res_tready
    );

endinterface
`default_nettype wire

// File: rtl/can_tx_arbiter_id_min_select.sv
`default_nettype none
// ============================================================================
//  Module   : can_id_min_select
//  Brief    : Finds the valid entry with the lowest CAN ID; ties -> lowest index.
//  Revision : 1.0 - initial release
// ============================================================================
module can_id_min_select
    import can_tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  wire logic [NUM_REQ-1:0]          valid,
    input  wire logic [NUM_REQ*CAN_ID_W-1:0] ids,
    output logic [$clog2(NUM_REQ)-1:0]       winner,
    output logic                             any_valid
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [CAN_ID_W-1:0] w_best_id;

    // Strict less-than keeps the earlier (lower) index on equal IDs
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        w_best_id = '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (valid[i] && (!any_valid || (ids[i*CAN_ID_W +: CAN_ID_W] < w_best_id))) begin
                any_valid = 1'b1;
                winner    = IDX_W'(i);
                w_best_id = ids[i*CAN_ID_W +: CAN_ID_W];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/can_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : can_tx_arbiter
//  Brief    : Lowest-ID arbiter sharing one CAN TX core among NUM_REQ sources.
//             Optional auto-resend on arbitration loss: CAN_TX_ARBITER_RETRY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module can_tx_arbiter
    import can_tx_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int MAX_RETRY = 3
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    can_tx_arbiter_if.slave                 bus,
    output logic                            busy,
    output logic [$clog2(NUM_REQ)-1:0]      grant_idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t         r_state;
    arb_state_t         w_state_next;
    can_frame_t         r_frame;
    can_frame_t         w_req_frame;
    logic [IDX_W-1:0]   r_grant_idx;
    logic [IDX_W-1:0]   w_winner;
    logic               w_any_valid;
    logic [2:0]         r_res;
    logic               w_req_hs;
    logic               w_res_hs;
    logic               w_retry;
    logic [NUM_REQ-1:0] w_req_tready;
    logic [NUM_REQ-1:0] w_res_tvalid;

    can_id_min_select #(
        .NUM_REQ   (NUM_REQ)
    ) u_min_select (
        .valid     (bus.req_tvalid),
        .ids       (bus.req_tid),
        .winner    (w_winner),
        .any_valid (w_any_valid)
    );

    assign w_req_hs = (r_state == IDLE) && w_any_valid;
    assign w_res_hs = (r_state == WAIT_RES) && bus.can_res_tvalid;

    always_comb begin
        w_req_frame.tid   = bus.req_tid[int'(w_winner)*CAN_ID_W +: CAN_ID_W];
        w_req_frame.tdata = bus.req_tdata[int'(w_winner)*CAN_DATA_W +: CAN_DATA_W];
        w_req_frame.tkeep = bus.req_tkeep[int'(w_winner)*CAN_KEEP_W +: CAN_KEEP_W];
    end

`ifdef CAN_TX_ARBITER_RETRY_EN
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [RETRY_W-1:0] r_retry;

    assign w_retry = bus.can_res_tdata[RES_ARB_LOST] && (r_retry < RETRY_W'(MAX_RETRY));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retry <= '0;
        end else if (w_req_hs) begin
            r_retry <= '0;
        end else if (w_res_hs && w_retry) begin
            r_retry <= r_retry + 1'b1;
        end
    end
`else
    assign w_retry = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (w_req_hs)                      w_state_next = SEND;
            SEND:     if (bus.can_tready)                w_state_next = WAIT_RES;
            WAIT_RES: if (w_res_hs)                      w_state_next = w_retry ? SEND : RESULT;
            RESULT:   if (bus.res_tready[r_grant_idx])   w_state_next = IDLE;
            default:                                     w_state_next = IDLE;
        endcase
    end

    // A lost-arbitration retry keeps the old result register untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame     <= '0;
            r_grant_idx <= '0;
            r_res       <= '0;
        end else begin
            if (w_req_hs) begin
                r_frame     <= w_req_frame;
                r_grant_idx <= w_winner;
            end
            if (w_res_hs && !w_retry) begin
                r_res <= bus.can_res_tdata;
            end
        end
    end

    always_comb begin
        w_req_tready = '0;
        w_res_tvalid = '0;
        if (w_req_hs) begin
            w_req_tready[w_winner] = 1'b1;
        end
        if (r_state == RESULT) begin
            w_res_tvalid[r_grant_idx] = 1'b1;
        end
    end

    assign bus.req_tready     = w_req_tready;
    assign bus.res_tvalid     = w_res_tvalid;
    assign bus.res_tdata      = r_res;
    assign bus.can_tvalid     = (r_state == SEND);
    assign bus.can_tid        = r_frame.tid;
    assign bus.can_tdata      = r_frame.tdata;
    assign bus.can_tkeep      = r_frame.tkeep;
    assign bus.can_res_tready = (r_state == WAIT_RES);
    assign busy               = (r_state != IDLE);
    assign grant_idx          = r_grant_idx;

endmodule
`default_nettype wire

// File: tb/tb_can_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_can_tx_arbiter
//  Brief    : Randomized self-checking bench for can_tx_arbiter (NUM_REQ=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_can_tx_arbiter;
    import can_tx_arb_pkg::*;

    localparam int NUM_REQ   = 2;
    localparam int MAX_RETRY = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [0:0] grant_idx;

    int n_checks = 0;
    int n_pass   = 0;

    // Requester-side picture of pending frames
    logic [10:0] m_tid   [NUM_REQ];
    logic [63:0] m_data  [NUM_REQ];
    logic [7:0]  m_keep  [NUM_REQ];
    bit          m_valid [NUM_REQ];
    bit   [2:0]  res_q[$];

    always #5 clk = ~clk;

    can_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    can_tx_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_tvalid[i]          = m_valid[i];
            bus.req_tid[i*11 +: 11]    = m_tid[i];
            bus.req_tdata[i*64 +: 64]  = m_data[i];
            bus.req_tkeep[i*8 +: 8]    = m_keep[i];
        end
    endtask

    // Bus priority: lowest ID wins, equal IDs go to the lowest requester number
    function automatic int model_winner();
        int w = -1;
        for (int i = 0; i < NUM_REQ; i++)
            if (m_valid[i] && (w < 0 || m_tid[i] < m_tid[w])) w = i;
        return w;
    endfunction

    function automatic bit model_retry(input int attempt, input bit [2:0] r);
`ifdef CAN_TX_ARBITER_RETRY_EN
        return r[2] && (attempt < MAX_RETRY);
`else
        return 1'b0;
`endif
    endfunction

    task automatic set_req(input int i, input logic [10:0] tid);
        m_valid[i] = 1'b1;
        m_tid[i]   = tid;
        m_data[i]  = {$urandom, $urandom};
        m_keep[i]  = 8'($urandom);
    endtask

    // Called at a negedge with the DUT idle; returns the granted index and attempt count
    task automatic run_txn(output int w, output int n_att);
        logic [10:0] e_tid;
        logic [63:0] e_data;
        logic [7:0]  e_keep;
        bit   [2:0]  r;
        bit          again;
        n_att = 0;
        drive_reqs();
        #1;
        w = model_winner();
        check("idle_busy", busy, 0);
        check("req_tready", bus.req_tready, (w < 0) ? 64'd0 : (64'd1 << w));
        if (w < 0) begin
            @(negedge clk);
            return;
        end
        e_tid  = m_tid[w];
        e_data = m_data[w];
        e_keep = m_keep[w];
        @(negedge clk);
        m_valid[w] = 1'b0;
        drive_reqs();
        again = 1'b1;
        while (again) begin
            check("can_tvalid", bus.can_tvalid, 1);
            check("can_tid", bus.can_tid, e_tid);
            check("can_tdata", bus.can_tdata, e_data);
            check("can_tkeep", bus.can_tkeep, e_keep);
            check("grant_idx", grant_idx, w);
            check("busy_send", busy, 1);
            check("ready_when_busy", bus.req_tready, 0);
            bus.can_tready = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                check("can_hold_valid", bus.can_tvalid, 1);
                check("can_hold_tid", bus.can_tid, e_tid);
                check("can_hold_tdata", bus.can_tdata, e_data);
            end
            bus.can_tready = 1'b1;
            @(negedge clk);
            bus.can_tready = 1'b0;
            check("wait_can_tvalid", bus.can_tvalid, 0);
            check("wait_res_tready", bus.can_res_tready, 1);
            check("wait_res_tvalid", bus.res_tvalid, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            r = (res_q.size() > 0) ? res_q.pop_front() : 3'($urandom);
            bus.can_res_tvalid = 1'b1;
            bus.can_res_tdata  = r;
            @(negedge clk);
            bus.can_res_tvalid = 1'b0;
            bus.can_res_tdata  = 3'($urandom);
            again = model_retry(n_att, r);
            n_att++;
        end
        check("res_tvalid", bus.res_tvalid, 64'd1 << w);
        check("res_tdata", bus.res_tdata, r);
        check("res_core_ready", bus.can_res_tready, 0);
        bus.res_tready = ~(2'd1 << w);
        repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            check("res_hold_valid", bus.res_tvalid, 64'd1 << w);
            check("res_hold_data", bus.res_tdata, r);
        end
        bus.res_tready = 2'b11;
        @(negedge clk);
        bus.res_tready = 2'b00;
        check("back_idle_busy", busy, 0);
        check("back_idle_res_tvalid", bus.res_tvalid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n_att;
        rst                = 1'b1;
        bus.req_tvalid     = '0;
        bus.req_tid        = '0;
        bus.req_tdata      = '0;
        bus.req_tkeep      = '0;
        bus.res_tready     = '0;
        bus.can_tready     = 1'b0;
        bus.can_res_tdata  = '0;
        bus.can_res_tvalid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            m_valid[i] = 1'b0;
            m_tid[i]   = '0;
            m_data[i]  = '0;
            m_keep[i]  = '0;
        end
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_grant_idx", grant_idx, 0);
        check("rst_can_tvalid", bus.can_tvalid, 0);
        check("rst_can_tid", bus.can_tid, 0);
        check("rst_can_tdata", bus.can_tdata, 0);
        check("rst_res_tvalid", bus.res_tvalid, 0);
        check("rst_res_tdata", bus.res_tdata, 0);
        check("rst_can_res_tready", bus.can_res_tready, 0);
        rst = 1'b0;
        @(negedge clk);

        // Simultaneous requests: lower ID first
        set_req(0, 11'h3E9);
        set_req(1, 11'h3D9);
        res_q.push_back(3'b010);
        run_txn(w, n_att);
        check("prio_first", w, 1);
        res_q.push_back(3'b011);
        run_txn(w, n_att);
        check("prio_second", w, 0);

        // Equal IDs: requester 0 first
        set_req(0, 11'h100);
        set_req(1, 11'h100);
        run_txn(w, n_att);
        check("tie_first", w, 0);
        run_txn(w, n_att);
        check("tie_second", w, 1);

        // Arbitration-loss handling
        set_req(1, 11'h055);
        res_q = '{3'b100, 3'b100, 3'b100, 3'b000};
        run_txn(w, n_att);
`ifdef CAN_TX_ARBITER_RETRY_EN
        check("retry_recover_attempts", n_att, 4);
`else
        check("noretry_attempts", n_att, 1);
`endif
        res_q.delete();
        set_req(0, 11'h056);
        res_q = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
        run_txn(w, n_att);
`ifdef CAN_TX_ARBITER_RETRY_EN
        check("retry_exhaust_attempts", n_att, 4);
`else
        check("noretry_attempts2", n_att, 1);
`endif
        res_q.delete();

        // Async reset while waiting for the core result
        set_req(1, 11'h200);
        drive_reqs();
        @(negedge clk);
        m_valid[1] = 1'b0;
        drive_reqs();
        bus.can_tready = 1'b1;
        @(negedge clk);
        bus.can_tready = 1'b0;
        check("pre_rst_wait", bus.can_res_tready, 1);
        check("pre_rst_grant", grant_idx, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_grant_idx", grant_idx, 0);
        check("mid_rst_can_tvalid", bus.can_tvalid, 0);
        check("mid_rst_res_tvalid", bus.res_tvalid, 0);
        check("mid_rst_can_res_tready", bus.can_res_tready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        set_req(0, 11'h010);
        run_txn(w, n_att);
        check("post_rst_grant", w, 0);

        // Random traffic; unserved requests stay pending across grants
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (!m_valid[i] && ($urandom_range(0, 2) != 0))
                    set_req(i, ($urandom_range(0, 3) == 0) ? 11'h123 : 11'($urandom));
            run_txn(w, n_att);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
